// File: rtl/filter2d_lb.sv
// 3x3 2-D convolution engine over an image held in a shared single-port SRAM.
// Two line buffers give one SRAM read per pixel; each scan position takes 3 cycles.
module filter2d_lb #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 17,
    parameter int WR_BASE = 65536,
    parameter int COEF_W  = 8,
    parameter int SHIFT   = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     finish,
    output logic                     cs,
    output logic                     we,
    output logic [ADDR_W-1:0]        addr,
    output logic [7:0]               din,
    input  logic [7:0]               dout,
    input  logic                     h_write,
    input  logic [3:0]               h_idx,
    input  logic signed [COEF_W-1:0] h_data
);

    localparam int ACC_W = COEF_W + 13;
    localparam int CW    = $clog2(IMG_W + 1);
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int LW    = $clog2(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H);
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(1) <<< (SHIFT - 1);
    localparam int COEF_DEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               phase_q, phase_d;
    logic [1:0]               mode_q, mode_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic [2:0][2:0][7:0]     win_q, win_d;
    logic signed [COEF_W-1:0] coef_q [9];
    logic signed [COEF_W-1:0] coef_d [9];
    logic [7:0]               lb0_q [IMG_W];
    logic [7:0]               lb1_q [IMG_W];

    logic                     run, start_acc, col_pad, in_img, last_step, lb_we;
    logic [LW-1:0]            lb_idx;
    logic [2:0][7:0]          new_col;
    logic [ADDR_W-1:0]        rd_addr, wr_addr;
    logic signed [ACC_W-1:0]  sum, mag, rnd;
    logic [7:0]               result;

    assign run       = (state_q == ST_RUN);
    assign start_acc = (state_q == ST_IDLE) && start;
    assign col_pad   = (col_q == COL_LAST);
    assign in_img    = (row_q < ROW_LAST) && !col_pad;
    assign last_step = run && (phase_q == 2'd2) && (row_q == ROW_LAST) && col_pad;
    assign lb_we     = run && (phase_q == 2'd1) && !col_pad;
    assign lb_idx    = col_q[LW-1:0];

    assign rd_addr = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
    assign wr_addr = ADDR_W'(WR_BASE) + (ADDR_W'(row_q) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                   + ADDR_W'(col_q) - ADDR_W'(1);

    // Incoming column: rows r-2 and r-1 come from the line buffers, row r from SRAM.
    always_comb begin
        new_col[0] = (row_q >= RW'(2) && !col_pad) ? lb0_q[lb_idx] : 8'd0;
        new_col[1] = (row_q >= RW'(1) && !col_pad) ? lb1_q[lb_idx] : 8'd0;
        new_col[2] = in_img ? dout : 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        row_d   = row_q;
        col_d   = col_q;
        mode_d  = mode_q;
        win_d   = win_q;
        coef_d  = coef_q;
        if (start_acc) begin
            phase_d = 2'd0;
            row_d   = '0;
            col_d   = '0;
            win_d   = '0;
            mode_d  = (mode == 2'd3) ? 2'd0 : mode;
        end else if (run) begin
            case (phase_q)
                2'd0: phase_d = 2'd1;
                2'd1: begin
                    phase_d = 2'd2;
                    for (int i = 0; i < 3; i++) begin
                        win_d[i][0] = win_q[i][1];
                        win_d[i][1] = win_q[i][2];
                        win_d[i][2] = new_col[i];
                    end
                end
                default: begin
                    phase_d = 2'd0;
                    if (col_pad) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            endcase
        end
        if (h_write && !run && h_idx <= 4'd8) coef_d[h_idx] = h_data;
    end

    // Unsigned pixels times signed taps; rounding then clamping to 0..255.
    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++)
            sum = sum + ACC_W'($signed({1'b0, win_q[k/3][k%3]})) * ACC_W'(coef_q[k]);
        mag = (mode_q == 2'd2 && sum < 0) ? -sum : sum;
        rnd = (mag + RND_OFS) >>> SHIFT;
        if (rnd < 0)                  result = 8'd0;
        else if (rnd > ACC_W'(255))   result = 8'hFF;
        else                          result = rnd[7:0];
        if (mode_q == 2'd1) result = win_q[1][1];
    end

    always_comb begin
        busy   = run;
        finish = (state_q == ST_DONE);
        cs     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        din    = '0;
        if (run) begin
            if (phase_q == 2'd0 && in_img) begin
                cs   = 1'b1;
                addr = rd_addr;
            end else if (phase_q == 2'd2 && row_q != '0 && col_q != '0) begin
                cs   = 1'b1;
                we   = 1'b1;
                addr = wr_addr;
                din  = result;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            phase_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= '0;
            win_q   <= '0;
            for (int k = 0; k < 9; k++) coef_q[k] <= COEF_W'(COEF_DEF[k]);
        end else begin
            phase_q <= phase_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            win_q   <= win_d;
            coef_q  <= coef_d;
        end
    end

    // NOTE: line buffers are plain storage with no reset; each row rewrites them before use.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb0_q[lb_idx] <= lb1_q[lb_idx];
            lb1_q[lb_idx] <= dout;
        end
    end

endmodule

// File: tb/tb_filter2d_lb.sv
// Scoreboard bench for filter2d_lb on a small 4x3 image with an SRAM model.
// Expected pixels come from a direct 3x3 neighbourhood model with zero padding.
module tb_filter2d_lb;

    localparam int W        = 4;
    localparam int H        = 3;
    localparam int AW       = 8;
    localparam int BASE     = 128;
    localparam int CWD      = 8;
    localparam int SH       = 7;
    localparam int RUN_CYC  = 3 * (H + 1) * (W + 1);
    localparam int FIRST_WR = 3 * (W + 2) + 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [1:0]            mode;
    logic                  busy, finish, cs, we;
    logic [AW-1:0]         addr;
    logic [7:0]            din;
    logic [7:0]            dout = 8'd0;
    logic                  h_write;
    logic [3:0]            h_idx;
    logic signed [CWD-1:0] h_data;

    filter2d_lb #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .WR_BASE(BASE), .COEF_W(CWD), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy),
        .finish(finish), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
        .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (cs && !we) dout <= mem[addr];
    end

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  img [W*H];
    int  hk  [9];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0, busy_cnt = 0, fin_cnt = 0, wr_cnt = 0, first_rd = -1, first_wr = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_px(input int y, input int x, input int md);
        int s = 0;
        if (md == 1) return img[y*W + x];
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (y+dy >= 0 && y+dy < H && x+dx >= 0 && x+dx < W)
                    s += img[(y+dy)*W + x+dx] * hk[(dy+1)*3 + dx+1];
        if (md == 2 && s < 0) s = -s;
        s = (s + (1 << (SH-1))) >>> SH;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic set_defaults();
        hk = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
    endtask

    task automatic set_coef(input int idx, input int val, input bit upd);
        @(posedge clk); #1;
        h_write = 1'b1; h_idx = 4'(idx); h_data = CWD'(val);
        @(posedge clk); #1;
        h_write = 1'b0;
        if (upd && idx <= 8) hk[idx] = val;
    endtask

    task automatic load_img(input int kind, input int val);
        for (int i = 0; i < W*H; i++) begin
            img[i] = (kind == 0) ? i : (kind == 1) ? val : int'($urandom_range(0, 255));
            mem[i] = 8'(img[i]);
        end
    endtask

    task automatic push_expect(input int md);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{BASE + y*W + x, model_px(y, x, md)});
    endtask

    task automatic pulse_start(input int md);
        @(posedge clk); #1;
        start = 1'b1; mode = 2'(md);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!finish && n < RUN_CYC + 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finish_seen"}, int'(finish), 1);
    endtask

    task automatic run_checks(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_busy_cycles"}, busy_cnt, RUN_CYC);
        check({name, "_finish_pulses"}, fin_cnt, 1);
        check({name, "_write_count"}, wr_cnt, W*H);
        check({name, "_first_read"}, first_rd, 1);
        check({name, "_first_write"}, first_wr, FIRST_WR);
        check({name, "_left_in_queue"}, exp_q.size(), 0);
    endtask

    task automatic full_run(input int md, input string name);
        push_expect(md);
        pulse_start(md);
        wait_done(name);
        run_checks(name);
    endtask

    // Monitor: tracks timing relative to start acceptance and scores every write.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (start && !busy && !finish) begin
                    cyc = 0; busy_cnt = 0; fin_cnt = 0; wr_cnt = 0;
                    first_rd = -1; first_wr = -1;
                end else begin
                    cyc++;
                end
                if (busy)   busy_cnt++;
                if (finish) fin_cnt++;
                if (cs && !we && first_rd < 0) first_rd = cyc;
                if (cs && we) begin
                    wr_cnt++;
                    if (first_wr < 0) first_wr = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL spurious_write: addr %0d data %0d with no expectation", addr, din);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check($sformatf("wr_addr@%0d", e.a), int'(addr), e.a);
                        check($sformatf("wr_data@%0d", e.a), int'(din), e.d);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'd0;
        h_write = 1'b0; h_idx = 4'd0; h_data = '0;
        set_defaults();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_cs", int'(cs), 0);
        check("rst_we", int'(we), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_din", int'(din), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        load_img(0, 0);
        full_run(1, "bypass_ramp");

        load_img(1, 100);
        full_run(0, "uniform100");

        // Start and coefficient writes while running must be ignored.
        load_img(2, 0);
        push_expect(0);
        pulse_start(0);
        repeat (10) @(posedge clk);
        pulse_start(1);
        set_coef(4, 0, 1'b0);
        wait_done("ignore_in_run");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_checks("ignore_in_run");
        check("idle_after_done_start", int'(busy), 0);

        set_coef(12, 0, 1'b1);
        load_img(2, 0);
        full_run(2, "bad_idx_abs");

        load_img(1, 255);
        for (int k = 0; k < 9; k++) set_coef(k, (k == 4) ? -128 : 0, 1'b1);
        full_run(0, "neg_centre_filter");
        full_run(2, "neg_centre_abs");

        for (int k = 0; k < 9; k++) set_coef(k, 127, 1'b1);
        full_run(0, "saturate");
        load_img(2, 0);
        full_run(3, "mode3_random");

        // Abort mid-run; coefficients must come back as defaults.
        set_coef(4, 5, 1'b1);
        load_img(2, 0);
        push_expect(0);
        pulse_start(0);
        repeat (20) @(posedge clk);
        #2;
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_finish", int'(finish), 0);
        check("abort_cs", int'(cs), 0);
        check("abort_we", int'(we), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cs_in_reset", int'(cs), 0);
        end
        exp_q.delete();
        set_defaults();
        @(posedge clk); #1;
        reset = 1'b0;
        load_img(2, 0);
        full_run(0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
